alu_sequencer: RTL and testbench

Program sequencer for the 8-bit ALU. It fetches 16-bit instructions from a synchronous program memory and drives the ALU opcode and operands. Results return to an internal accumulator and carry flag. It also executes the bit-clear, bit-set and halt operations that the ALU itself leaves unimplemented, and sits between the program store and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU program sequencer: FSM states, opcodes and
// instruction-word field positions.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_INC   = 4'd5;
    localparam logic [3:0] OP_DEC   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_NOPC  = 4'd8;
    localparam logic [3:0] OP_ZERO  = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_SWAP  = 4'd11;
    localparam logic [3:0] OP_NOT   = 4'd12;
    localparam logic [3:0] OP_BCLR  = 4'd13;
    localparam logic [3:0] OP_BSET  = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [3:0] OP_NOP = 4'b1000;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RSV_BIT = 11;
    localparam int IDX_HI = 10;
    localparam int IDX_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Only the arithmetic ops refresh the sticky carry.
    function automatic logic updates_carry(input logic [3:0] op);
        logic res;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving an external 8-bit ALU from a
// synchronous program store; bit-clear, bit-set and halt are handled here.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    output logic              prog_rd,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    output logic [3:0]        alu_inst,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_ans,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] acc,
    output logic              carry_flag,
    output logic              busy,
    output logic              done
);

    state_t              state_r;
    logic [PC_W-1:0]     pc_r;
    logic [15:0]         ir_r;
    logic [DATA_W-1:0]   acc_r;
    logic                carry_r;

    logic [3:0]          op_s;
    logic [2:0]          idx_s;
    logic [7:0]          imm_s;
    logic                rsv_unused_s;
    logic [3:0]          alu_inst_s;
    logic [DATA_W-1:0]   alu_b_s;

    assign op_s         = ir_r[OP_HI:OP_LO];
    assign idx_s        = ir_r[IDX_HI:IDX_LO];
    assign imm_s        = ir_r[IMM_HI:IMM_LO];
    assign rsv_unused_s = ir_r[RSV_BIT];

    // Sequencer FSM plus architectural state (pc, ir, acc, carry).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            pc_r    <= '0;
            ir_r    <= 16'h0000;
            acc_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pc_r    <= start_addr;
                        state_r <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: state_r <= DECODE;
                DECODE: begin
                    ir_r <= prog_data;
                    pc_r <= pc_r + PC_W'(1);
                    if (prog_data[OP_HI:OP_LO] == OP_HALT) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_s)
                        OP_NOPC, OP_HALT: acc_r <= acc_r;
                        OP_BCLR:          acc_r[idx_s] <= 1'b0;
                        OP_BSET:          acc_r[idx_s] <= 1'b1;
                        default:          acc_r <= alu_ans;
                    endcase
                    if (updates_carry(op_s)) begin
                        carry_r <= alu_carry;
                    end else begin
                        carry_r <= carry_r;
                    end
                    state_r <= FETCH;
                end
                HALT:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // ALU drive: only ALU ops in EXEC see the real opcode and immediate.
    always_comb begin
        alu_inst_s = OP_NOP;
        alu_b_s    = '0;
        if (state_r == EXEC && op_s != OP_BCLR && op_s != OP_BSET) begin
            alu_inst_s = op_s;
            alu_b_s    = DATA_W'(imm_s);
        end else begin
            alu_inst_s = OP_NOP;
            alu_b_s    = '0;
        end
    end

    assign prog_rd    = (state_r == FETCH);
    assign prog_addr  = pc_r;
    assign alu_inst   = alu_inst_s;
    assign alu_a      = acc_r;
    assign alu_b      = alu_b_s;
    assign acc        = acc_r;
    assign carry_flag = carry_r;
    assign busy       = (state_r != IDLE);
    assign done       = (state_r == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and ROM beside the DUT, checked
// against an instruction-level program model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic        prog_rd;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data = 16'h0000;
    logic [3:0]  alu_inst;
    logic [7:0]  alu_a, alu_b, alu_ans, acc;
    logic        alu_carry, carry_flag, busy, done;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [256];

    int m_acc = 0;
    int m_carry = 0;
    int exp_acc[$];
    int exp_inst[$];

    alu_sequencer #(.PC_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ans(alu_ans), .alu_carry(alu_carry),
        .acc(acc), .carry_flag(carry_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Program store with one-cycle read latency.
    always @(posedge clk) begin
        if (prog_rd) prog_data <= rom[prog_addr];
    end

    // Behavioural ALU: {carry, result} as a 9-bit value.
    logic [8:0] alu_r;
    always_comb begin
        case (alu_inst)
            4'd0:    alu_r = {1'b0, alu_b};
            4'd1:    alu_r = {1'b0, alu_a};
            4'd2:    alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            4'd3:    alu_r = {1'b0, alu_b} - {1'b0, alu_a};
            4'd4:    alu_r = {1'b0, alu_a & alu_b};
            4'd5:    alu_r = {1'b0, alu_a} + 9'd1;
            4'd6:    alu_r = {1'b0, alu_a} - 9'd1;
            4'd7:    alu_r = {1'b0, alu_a | alu_b};
            4'd9:    alu_r = 9'd0;
            4'd10:   alu_r = {1'b0, alu_a ^ alu_b};
            4'd11:   alu_r = {1'b0, alu_a[3:0], alu_a[7:4]};
            4'd12:   alu_r = {1'b0, ~alu_a};
            default: alu_r = {1'b0, alu_a};
        endcase
    end
    assign alu_ans   = alu_r[7:0];
    assign alu_carry = alu_r[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: walks the ROM from addr to the first HALT.
    task automatic model_run(input int addr, output int ninst);
        int pc, w, op, imm, idx, d;
        pc = addr;
        ninst = 0;
        exp_acc.delete();
        exp_inst.delete();
        for (int k = 0; k < 64; k++) begin
            w = int'(rom[pc]);
            pc = (pc + 1) % 256;
            op = w / 4096;
            idx = (w / 256) % 8;
            imm = w % 256;
            if (op == 15) break;
            ninst++;
            case (op)
                0:  m_acc = imm;
                2:  begin d = m_acc + imm; m_carry = (d > 255) ? 1 : 0; m_acc = d % 256; end
                3:  begin d = imm - m_acc; m_carry = (d < 0) ? 1 : 0; m_acc = (d + 256) % 256; end
                4:  m_acc = m_acc & imm;
                5:  begin m_carry = (m_acc == 255) ? 1 : 0; m_acc = (m_acc + 1) % 256; end
                6:  begin m_carry = (m_acc == 0) ? 1 : 0; m_acc = (m_acc + 255) % 256; end
                7:  m_acc = m_acc | imm;
                9:  m_acc = 0;
                10: m_acc = m_acc ^ imm;
                11: m_acc = (m_acc % 16) * 16 + m_acc / 16;
                12: m_acc = 255 - m_acc;
                13: m_acc = m_acc & (255 - (1 << idx));
                14: m_acc = m_acc | (1 << idx);
                default: ;
            endcase
            exp_acc.push_back(m_acc);
            exp_inst.push_back(op <= 12 ? op : 8);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_prog_rd"}, prog_rd, 0);
        chk({tag, "_prog_addr"}, prog_addr, 0);
        chk({tag, "_alu_inst"}, alu_inst, 8);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_acc"}, acc, 0);
        chk({tag, "_carry"}, carry_flag, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Start a program and follow it cycle by cycle; cycle 1 is the first FETCH.
    task automatic run_prog(input int addr, input bit mid_start, input bit do_reset);
        int n, cyc, busyc;
        model_run(addr, n);
        @(negedge clk);
        start_addr = 8'(addr);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busyc = busy ? 1 : 0;
        while (!done && cyc < 500) begin
            if (cyc % 3 == 0 && cyc / 3 <= n)
                chk("alu_inst_exec", alu_inst, exp_inst[cyc/3-1]);
            if (cyc % 3 == 1 && cyc > 1 && (cyc - 1) / 3 <= n)
                chk("acc_step", acc, exp_acc[(cyc-1)/3-1]);
            if (do_reset && cyc == 6) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk_reset_outputs("mid_reset");
                m_acc = 0;
                m_carry = 0;
                return;
            end
            if (mid_start) begin
                start_addr = 8'h10;
                start = (cyc == 2);
            end
            @(posedge clk); #1;
            cyc++;
            if (busy) busyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("done_cycle", cyc, 3 * n + 3);
        chk("busy_cycles", busyc, 3 * n + 3);
        chk("acc_final", acc, m_acc);
        chk("carry_final", carry_flag, m_carry);
        @(posedge clk); #1;
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    task automatic load(input int addr, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3,
                        input logic [15:0] w4, input logic [15:0] w5);
        rom[addr % 256]       = w0;
        rom[(addr + 1) % 256] = w1;
        rom[(addr + 2) % 256] = w2;
        rom[(addr + 3) % 256] = w3;
        rom[(addr + 4) % 256] = w4;
        rom[(addr + 5) % 256] = w5;
    endtask

    initial begin
        int a, n;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        load(0, 16'h002A, 16'h2010, 16'hF000, 16'hF000, 16'hF000, 16'hF000);
        run_prog(0, 1'b0, 1'b0);
        chk("add_acc", acc, 8'h3A);
        chk("add_carry", carry_flag, 0);

        load(0, 16'h00FF, 16'h5000, 16'h4000, 16'hF000, 16'hF000, 16'hF000);
        run_prog(0, 1'b0, 1'b0);
        chk("inc_acc", acc, 8'h00);
        chk("and_keeps_carry", carry_flag, 1);

        load(0, 16'h0005, 16'h3003, 16'hF000, 16'hF000, 16'hF000, 16'hF000);
        run_prog(0, 1'b0, 1'b0);
        chk("sub_acc", acc, 8'hFE);
        chk("sub_carry", carry_flag, 1);

        load(0, 16'h9000, 16'hE700, 16'hE000, 16'hD700, 16'hB000, 16'hF000);
        run_prog(0, 1'b0, 1'b0);
        chk("bitops_acc", acc, 8'h10);

        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        rom[8'hFF] = 16'h0033;
        run_prog(255, 1'b1, 1'b0);
        chk("wrap_acc", acc, 8'h33);

        load(0, 16'h002A, 16'h2010, 16'hF000, 16'hF000, 16'hF000, 16'hF000);
        run_prog(0, 1'b0, 1'b1);
        run_prog(0, 1'b0, 1'b0);
        chk("rerun_acc", acc, 8'h3A);

        for (int r = 0; r < 24; r++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                rom[(a + i) % 256] = {4'($urandom_range(0, 14)), 12'($urandom)};
            rom[(a + n) % 256] = 16'hF000;
            run_prog(a, ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
